// File: rtl/univ_shift_reg_n.sv
// univ_shift_reg_n: universal shift register, multi-bit shifts run one bit per clock under start/busy/done
module univ_shift_reg_n #(
   parameter int WIDTH = 8,
   parameter int AMT_W = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [2:0]       i_mode,
   input  logic [AMT_W-1:0] i_amount,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_sin_l,
   input  logic             i_sin_r,
   output logic [WIDTH-1:0] o_q,
   output logic             o_sout_l,
   output logic             o_sout_r,
   output logic             o_busy,
   output logic             o_done
);
   localparam logic [2:0] HOLD = 3'd0, LOAD = 3'd1, SHL = 3'd2, SHR = 3'd3,
                          ROL = 3'd4, ROR = 3'd5, ASR = 3'd6, CLR = 3'd7;

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state, state_n;
   logic [AMT_W-1:0] cnt, cnt_n;
   logic [2:0]       mode_r, mode_n, step_mode;
   logic [WIDTH-1:0] q_n, stepped;
   logic             done_n, accept, single;

   function automatic logic [WIDTH-1:0] step(input logic [2:0] m, input logic [WIDTH-1:0] v,
                                             input logic sl, input logic sr);
      return m == SHL ? {v[WIDTH-2:0], sr} :
             m == SHR ? {sl, v[WIDTH-1:1]} :
             m == ROL ? {v[WIDTH-2:0], v[WIDTH-1]} :
             m == ROR ? {v[0], v[WIDTH-1:1]} :
             m == ASR ? {v[WIDTH-1], v[WIDTH-1:1]} : v;
   endfunction

   always_comb begin
      accept    = i_start && state == IDLE;
      single    = i_mode == HOLD || i_mode == LOAD || i_mode == CLR;
      step_mode = accept ? i_mode : mode_r;
      stepped   = step(step_mode, o_q, i_sin_l, i_sin_r);
      state_n   = state;
      cnt_n     = cnt;
      mode_n    = mode_r;
      q_n       = o_q;
      done_n    = 1'b0;
      if (accept) begin
         mode_n = i_mode;
         done_n = single || i_amount <= AMT_W'(1);
         if (single)
            q_n = i_mode == LOAD ? i_data : i_mode == CLR ? '0 : o_q;
         else if (i_amount != '0)
            q_n = stepped;
         if (!single && i_amount > AMT_W'(1)) begin
            cnt_n   = i_amount - AMT_W'(1);
            state_n = RUN;
         end
      end else if (state == RUN) begin
         q_n   = stepped;
         cnt_n = cnt - AMT_W'(1);
         if (cnt == AMT_W'(1)) begin
            state_n = IDLE;
            done_n  = 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state  <= IDLE;
         cnt    <= '0;
         mode_r <= HOLD;
         o_q    <= '0;
         o_done <= 1'b0;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         mode_r <= mode_n;
         o_q    <= q_n;
         o_done <= done_n;
      end
   end

   assign o_busy   = state == RUN;
   assign o_sout_l = o_q[WIDTH-1];
   assign o_sout_r = o_q[0];
endmodule

// File: tb/tb_univ_shift_reg_n.sv
// tb_univ_shift_reg_n: random and directed stimulus checked against an arithmetic model of the register
module tb_univ_shift_reg_n;
   localparam int W = 8, A = 4, M = 256;

   logic         i_clk = 1'b0, i_rst, i_start, i_sin_l, i_sin_r;
   logic [2:0]   i_mode;
   logic [A-1:0] i_amount;
   logic [W-1:0] i_data, o_q;
   logic         o_sout_l, o_sout_r, o_busy, o_done;

   int vectors = 0, miscompares = 0;
   int mq = 0, rem = 0, mmode = 0;
   bit mdone = 0, en = 0;

   univ_shift_reg_n #(.WIDTH(W), .AMT_W(A)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_mode(i_mode),
      .i_amount(i_amount), .i_data(i_data), .i_sin_l(i_sin_l), .i_sin_r(i_sin_r),
      .o_q(o_q), .o_sout_l(o_sout_l), .o_sout_r(o_sout_r), .o_busy(o_busy), .o_done(o_done)
   );

   always #5 i_clk = ~i_clk;

   function automatic int step(int m, int q, bit sl, bit sr);
      case (m)
         2: return (q * 2 + sr) % M;
         3: return q / 2 + sl * (M / 2);
         4: return (q * 2) % M + q / (M / 2);
         5: return q / 2 + (q % 2) * (M / 2);
         6: return q / 2 + (q >= M / 2 ? M / 2 : 0);
         default: return q;
      endcase
   endfunction

   always @(posedge i_clk) begin
      if (i_rst) begin
         mq = 0; rem = 0; mdone = 0;
      end else if (rem > 0) begin
         mq = step(mmode, mq, i_sin_l, i_sin_r);
         rem--;
         mdone = rem == 0;
      end else if (i_start) begin
         mmode = int'(i_mode);
         mdone = 1;
         if (i_mode == 3'd1) mq = int'(i_data);
         else if (i_mode == 3'd7) mq = 0;
         else if (i_mode != 3'd0 && i_amount != 0) begin
            mq = step(mmode, mq, i_sin_l, i_sin_r);
            rem = int'(i_amount) - 1;
            mdone = rem == 0;
         end
      end else mdone = 0;
   end

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   always @(negedge i_clk) if (en) begin
      check("q", 32'(o_q), mq);
      check("busy", 32'(o_busy), 32'(rem > 0));
      check("done", 32'(o_done), 32'(mdone));
      check("sout_l", 32'(o_sout_l), (mq / (M / 2)) % 2);
      check("sout_r", 32'(o_sout_r), mq % 2);
   end

   task automatic go(logic [2:0] m, logic [A-1:0] k, logic [W-1:0] d);
      i_start = 1; i_mode = m; i_amount = k; i_data = d;
      @(negedge i_clk);
      i_start = 0;
   endtask

   initial begin
      i_rst = 1; i_start = 0; i_mode = 0; i_amount = 0; i_data = 0; i_sin_l = 0; i_sin_r = 0;
      repeat (2) @(negedge i_clk);
      en = 1;
      check("rst_q", 32'(o_q), 0); check("rst_busy", 32'(o_busy), 0); check("rst_done", 32'(o_done), 0);
      i_rst = 0;
      @(negedge i_clk);
      check("idle_q", 32'(o_q), 0);
      go(3'd1, 0, 8'hB4);
      i_sin_r = 1;
      go(3'd2, 3, 0);
      check("shl_busy1", 32'(o_busy), 1);
      i_start = 1; i_mode = 3'd1; i_data = 8'hFF;
      @(negedge i_clk);
      i_start = 0;
      check("shl_busy2", 32'(o_busy), 1);
      @(negedge i_clk);
      check("shl_q", 32'(o_q), 8'hA7); check("shl_done", 32'(o_done), 1); check("shl_idle", 32'(o_busy), 0);
      @(negedge i_clk);
      check("ignored_q", 32'(o_q), 8'hA7); check("shl_done_off", 32'(o_done), 0);
      go(3'd1, 0, 8'h90); go(3'd6, 2, 0);
      @(negedge i_clk);
      check("asr_q", 32'(o_q), 8'hE4); check("asr_done", 32'(o_done), 1);
      go(3'd1, 0, 8'h81); go(3'd5, 1, 0);
      check("ror_q", 32'(o_q), 8'hC0); check("ror_busy", 32'(o_busy), 0); check("ror_done", 32'(o_done), 1);
      go(3'd1, 0, 8'h81); go(3'd4, 9, 0);
      repeat (8) @(negedge i_clk);
      check("rol_q", 32'(o_q), 8'h03); check("rol_done", 32'(o_done), 1);
      go(3'd7, 0, 0);
      i_sin_l = 1;
      go(3'd3, 8, 0);
      for (int i = 1; i < 8; i++) begin
         i_sin_l = i % 2 == 0;
         @(negedge i_clk);
      end
      check("shr_q", 32'(o_q), 8'h55); check("shr_done", 32'(o_done), 1);
      i_start = 1; i_mode = 3'd1; i_data = 8'h3C;
      @(negedge i_clk);
      check("b2b_load", 32'(o_q), 8'h3C); check("b2b_done1", 32'(o_done), 1);
      i_mode = 3'd0;
      @(negedge i_clk);
      check("b2b_hold", 32'(o_q), 8'h3C); check("b2b_done2", 32'(o_done), 1);
      i_mode = 3'd7;
      @(negedge i_clk);
      check("b2b_clr", 32'(o_q), 0); check("b2b_done3", 32'(o_done), 1);
      i_start = 0;
      go(3'd1, 0, 8'h5A); go(3'd2, 0, 0);
      check("k0_q", 32'(o_q), 8'h5A); check("k0_done", 32'(o_done), 1);
      @(negedge i_clk);
      check("k0_done_off", 32'(o_done), 0);
      go(3'd2, 5, 0);
      i_rst = 1;
      @(negedge i_clk);
      i_rst = 0;
      check("abort_q", 32'(o_q), 0); check("abort_busy", 32'(o_busy), 0); check("abort_done", 32'(o_done), 0);
      repeat (5) begin
         @(negedge i_clk);
         check("abort_no_done", 32'(o_done), 0);
      end
      for (int n = 0; n < 3000; n++) begin
         i_start  = $urandom_range(0, 2) == 0;
         i_mode   = 3'($urandom);
         i_amount = $urandom_range(0, 3) == 0 ? A'($urandom) : A'($urandom_range(0, 3));
         i_data   = W'($urandom);
         i_sin_l  = 1'($urandom);
         i_sin_r  = 1'($urandom);
         i_rst    = $urandom_range(0, 199) == 0;
         @(negedge i_clk);
      end
      i_rst = 0; i_start = 0;
      @(negedge i_clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
